// File: rtl/dav_rfd_receiver_if.sv
// dav_rfd_receiver_if
// Bundles the producer-side dav_/rfd byte handshake and the downstream
// valid/ready FIFO interface of dav_rfd_receiver.
//   data      : byte from producer, valid while dav_=0
//   dav_      : data-available from producer, active-low
//   rfd       : ready-for-data to producer (1 = idle/ready, 0 = byte taken)
//   out_data  : FIFO head
//   out_valid : FIFO non-empty
//   out_ready : downstream pops head when out_valid=1
//   count     : current FIFO occupancy
//   run_min   : running minimum of captured bytes (statistics option)
//   rx_cnt    : number of captured bytes (statistics option)
// Modport slave is the receiver's view; modport master is the environment's.
interface dav_rfd_receiver_if #(
  parameter int W     = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  data;
  logic          dav_;
  logic          rfd;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic [W-1:0]  run_min;
  logic [15:0]   rx_cnt;

  modport slave (
    input  data, dav_, out_ready,
    output rfd, out_data, out_valid, count, run_min, rx_cnt
  );

  modport master (
    output data, dav_, out_ready,
    input  rfd, out_data, out_valid, count, run_min, rx_cnt
  );
endinterface

// File: rtl/dav_rfd_receiver.sv
// dav_rfd_receiver
// Consumer end of the dav_/rfd byte handshake. Each handshake captures one
// byte into a small FIFO; buffered bytes are offered downstream over a
// valid/ready interface. While the FIFO is full, rfd is simply held high so
// the producer keeps waiting with dav_=0 until space appears.
// Ports:
//   clock : single system clock, rising edge
//   reset : synchronous, active-high
//   bus   : dav_rfd_receiver_if.slave (handshake, FIFO output, statistics)
// Optional feature: define RX_STATS_EN to enable the rx_cnt byte counter and
// the run_min running minimum. Without it, rx_cnt reads 0 and run_min reads
// all ones.
module dav_rfd_receiver #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  dav_rfd_receiver_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, ACK} state_t;

  state_t        state_reg;
  logic          rfd_reg;
  logic [AW-1:0] wptr_reg;
  logic [AW-1:0] rptr_reg;
  logic [CW-1:0] count_reg;

  logic [W-1:0]  entries [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Full/empty come from the occupancy count, so pointer equality is never
  // ambiguous. The capture decision sees the count before the edge: a pop at
  // the same edge as a full FIFO does not open a slot until the next cycle.
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign push  = (state_reg == IDLE) && !bus.dav_ && !full;
  assign pop   = !empty && bus.out_ready;

  // Storage: one register per entry, written when the write pointer selects it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [W-1:0] entry_reg;
    always_ff @(posedge clock) begin
      if (push && (wptr_reg == AW'(gi))) begin
        entry_reg <= bus.data;
      end
    end
    assign entries[gi] = entry_reg;
  end

  // Handshake FSM plus FIFO bookkeeping. ACK waits for dav_ to return high
  // before another capture, so a producer holding dav_=0 never duplicates.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      rfd_reg   <= 1'b1;
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (push) begin
            rfd_reg   <= 1'b0;
            state_reg <= ACK;
          end
        end
        ACK: begin
          if (bus.dav_) begin
            rfd_reg   <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          rfd_reg   <= 1'b1;
          state_reg <= IDLE;
        end
      endcase

      if (push) begin
        wptr_reg <= wptr_reg + AW'(1);
      end
      if (pop) begin
        rptr_reg <= rptr_reg + AW'(1);
      end

      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign bus.rfd       = rfd_reg;
  assign bus.out_data  = entries[rptr_reg];
  assign bus.out_valid = !empty;
  assign bus.count     = count_reg;

`ifdef RX_STATS_EN
  logic [15:0]  rx_cnt_reg;
  logic [W-1:0] run_min_reg;

  // Statistics follow capture edges only; the counter wraps naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_cnt_reg  <= '0;
      run_min_reg <= '1;
    end else if (push) begin
      rx_cnt_reg <= rx_cnt_reg + 16'd1;
      if (bus.data < run_min_reg) begin
        run_min_reg <= bus.data;
      end
    end
  end

  assign bus.rx_cnt  = rx_cnt_reg;
  assign bus.run_min = run_min_reg;
`else
  assign bus.rx_cnt  = '0;
  assign bus.run_min = '1;
`endif
endmodule

// File: tb/tb_dav_rfd_receiver.sv
// tb_dav_rfd_receiver
// Drives the dav_/rfd handshake from the producer side and checks every byte
// leaving the FIFO against a queue of expected bytes, plus occupancy, rfd and
// statistics outputs at the points of interest.
module tb_dav_rfd_receiver;
  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic clock;
  logic reset;

  int checks;
  int errors;
  logic [W-1:0] sb [$];
  int max_count;

  dav_rfd_receiver_if #(.W(W), .DEPTH(DEPTH)) bus ();

  dav_rfd_receiver #(.W(W), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output monitor: sampled mid-cycle; a pop will occur at the next edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (int'(bus.count) > max_count) max_count = int'(bus.count);
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pop_underflow: got out_data=%h, required no pop (scoreboard empty)", bus.out_data);
        end else begin
          logic [W-1:0] exp_byte;
          exp_byte = sb.pop_front();
          if (bus.out_data !== exp_byte) begin
            errors++;
            $display("FAIL pop_data: got %h, required %h", bus.out_data, exp_byte);
          end else begin
            $display("pop %h ok", bus.out_data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full handshake: present the byte, wait for rfd=0, release dav_.
  task automatic send_byte(input logic [W-1:0] b, input int budget);
    bit got;
    got = 0;
    bus.data = b;
    bus.dav_ = 1'b0;
    sb.push_back(b);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.rfd === 1'b0) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send_timeout: byte %h rfd=%b, required rfd=0 within %0d cycles", b, bus.rfd, budget);
    end
    bus.dav_ = 1'b1;
    tick();
    checks++;
    if (bus.rfd !== 1'b1) begin
      errors++;
      $display("FAIL send_release: rfd=%b, required 1", bus.rfd);
    end else begin
      $display("send %h ok", b);
    end
  endtask

  task automatic drain();
    bit done;
    done = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid === 1'b0) begin
        done = 1;
        break;
      end
    end
    bus.out_ready = 1'b0;
    checks++;
    if (!done || sb.size() != 0) begin
      errors++;
      $display("FAIL drain: out_valid=%b left=%0d, required 0 and 0", bus.out_valid, sb.size());
    end else begin
      $display("drain ok");
    end
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    if (bus.rfd !== 1'b1 || bus.count !== '0 || bus.out_valid !== 1'b0 ||
        bus.run_min !== 8'hFF || bus.rx_cnt !== 16'd0) begin
      errors++;
      $display("FAIL %s: rfd=%b count=%0d out_valid=%b run_min=%h rx_cnt=%0d, required 1 0 0 ff 0",
               tag, bus.rfd, bus.count, bus.out_valid, bus.run_min, bus.rx_cnt);
    end else begin
      $display("%s ok", tag);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.dav_ = 1'b1;
    bus.data = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_reset_state("reset_state");
    sb.delete();
  endtask

  task automatic test_single();
    bus.data = 8'h5A;
    bus.dav_ = 1'b0;
    sb.push_back(8'h5A);
    tick();
    checks++;
    if (bus.rfd !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h5A || bus.count !== 3'd1) begin
      errors++;
      $display("FAIL single_capture: rfd=%b out_valid=%b out_data=%h count=%0d, required 0 1 5a 1",
               bus.rfd, bus.out_valid, bus.out_data, bus.count);
    end else $display("single_capture ok");
    bus.dav_ = 1'b1;
    tick();
    checks++;
    if (bus.rfd !== 1'b1) begin
      errors++;
      $display("FAIL single_release: rfd=%b, required 1", bus.rfd);
    end else $display("single_release ok");
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
      errors++;
      $display("FAIL single_pop: out_valid=%b count=%0d, required 0 0", bus.out_valid, bus.count);
    end else $display("single_pop ok");
  endtask

  task automatic test_fill_backpressure();
    bus.out_ready = 1'b0;
    send_byte(8'h10, 5);
    send_byte(8'h20, 5);
    send_byte(8'h30, 5);
    send_byte(8'h40, 5);
    checks++;
    if (bus.count !== 3'd4) begin
      errors++;
      $display("FAIL fill_count: count=%0d, required 4", bus.count);
    end else $display("fill_count ok");
    bus.data = 8'h50;
    bus.dav_ = 1'b0;
    sb.push_back(8'h50);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.rfd !== 1'b1 || bus.count !== 3'd4) begin
        errors++;
        $display("FAIL full_hold cycle %0d: rfd=%b count=%0d, required 1 4", i, bus.rfd, bus.count);
      end else $display("full_hold cycle %0d ok", i);
    end
    // Pop while full: the slot opens, but capture waits one more edge.
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.rfd !== 1'b1 || bus.count !== 3'd3) begin
      errors++;
      $display("FAIL full_pop_edge: rfd=%b count=%0d, required 1 3", bus.rfd, bus.count);
    end else $display("full_pop_edge ok");
    tick();
    checks++;
    if (bus.rfd !== 1'b0 || bus.count !== 3'd4) begin
      errors++;
      $display("FAIL late_capture: rfd=%b count=%0d, required 0 4", bus.rfd, bus.count);
    end else $display("late_capture ok");
    bus.dav_ = 1'b1;
    tick();
    drain();
  endtask

  task automatic test_held_dav();
    bus.data = 8'h33;
    bus.dav_ = 1'b0;
    sb.push_back(8'h33);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.rfd !== 1'b0 || bus.count !== 3'd1) begin
        errors++;
        $display("FAIL held_dav cycle %0d: rfd=%b count=%0d, required 0 1", i, bus.rfd, bus.count);
      end else $display("held_dav cycle %0d ok", i);
    end
    bus.dav_ = 1'b1;
    tick();
    drain();
  endtask

  task automatic test_stream_wrap();
    max_count = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_byte(W'(i), 5);
    end
    tick();
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (max_count > 1 || sb.size() != 0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream: max_count=%0d left=%0d out_valid=%b, required <=1 0 0",
               max_count, sb.size(), bus.out_valid);
    end else $display("stream ok");
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    send_byte(8'hA1, 5);
    bus.data = 8'h07;
    bus.dav_ = 1'b0;
    tick();
    checks++;
    if (bus.rfd !== 1'b0 || bus.count !== 3'd2) begin
      errors++;
      $display("FAIL mid_ack: rfd=%b count=%0d, required 0 2", bus.rfd, bus.count);
    end else $display("mid_ack ok");
    reset = 1'b1;
    bus.dav_ = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    check_reset_state("reset_mid");
  endtask

  task automatic test_stats();
    logic [15:0] exp_cnt;
    logic [W-1:0] exp_min;
`ifdef RX_STATS_EN
    exp_cnt = 16'd3;
    exp_min = 8'h12;
`else
    exp_cnt = 16'd0;
    exp_min = 8'hFF;
`endif
    bus.out_ready = 1'b0;
    send_byte(8'h80, 5);
    send_byte(8'h12, 5);
    send_byte(8'hF0, 5);
    checks++;
    if (bus.rx_cnt !== exp_cnt || bus.run_min !== exp_min) begin
      errors++;
      $display("FAIL stats: rx_cnt=%0d run_min=%h, required %0d %h", bus.rx_cnt, bus.run_min, exp_cnt, exp_min);
    end else $display("stats ok");
    drain();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    max_count = 0;
    reset = 1'b1;
    bus.dav_ = 1'b1;
    bus.data = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_fill_backpressure();
    test_held_dav();
    test_stream_wrap();
    test_reset_mid();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/dav_rfd_receiver.md
Name: dav_rfd_receiver

Overview:
- Consumer end of the dav_/rfd byte handshake; pairs with the producer that drives data + dav_ and waits on rfd.
- Accepts one byte per handshake and buffers it in a small FIFO.
- Presents buffered bytes to downstream logic over a valid/ready interface.
- Applies back-pressure to the producer by withholding the rfd acknowledge while the FIFO is full.

Parameters:
- W, 8, data width in bits.
- DEPTH, 4, FIFO entries; power of 2, at least 2.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- data  input  W  byte from producer; valid while dav_=0.
- dav_  input  1  data-available from producer, active-low.
- rfd  output  1  ready-for-data to producer; 1 = idle/ready, 0 = byte taken.
- out_data  output  W  FIFO head.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  downstream pops head when out_valid=1.
- count  output  $clog2(DEPTH)+1  current occupancy.
- run_min  output  W  running minimum (see Optional Feature).
- rx_cnt  output  16  bytes accepted (see Optional Feature).

Behaviour:
- Interface is fixed:
  - One clock, named clock.
  - Reset named reset, synchronous and active-high: sampled only on the rising edge of clock; reset=1 at an edge forces reset state.
- Reset values:
  - STATE=IDLE, rfd=1.
  - FIFO empty: count=0, out_valid=0.
  - Read and write pointers 0.
  - out_data = entry[0] (don't-care while empty).
  - run_min=all ones, rx_cnt=0.
- Handshake FSM, two states; rfd is a registered output.
  - IDLE (rfd=1):
    - If dav_=0 and count<DEPTH at an edge: write data into FIFO[wptr], wptr+1 mod DEPTH, rfd<=0, go to ACK.
    - If dav_=0 and FIFO full: stay in IDLE with rfd=1, no capture. The producer waits; capture happens at the first edge with space.
    - If dav_=1: stay in IDLE.
  - ACK (rfd=0):
    - If dav_=1: rfd<=1, go to IDLE.
    - Otherwise stay; no further capture, so a held dav_=0 never duplicates a byte.
- Throughput: one byte per 2 clocks minimum when the producer reacts in 1 clock.
- Capture latency: byte visible at out_data/out_valid the cycle after the capture edge when the FIFO was empty.
- Pop: out_valid & out_ready at an edge → rptr+1 mod DEPTH.
- count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push+pop.
- Full rule: the capture decision uses count before the edge. When count==DEPTH, a same-cycle pop does not enable capture; capture occurs next cycle.
- Empty: out_valid=0; out_ready ignored; pointers hold.
- Pointer wrap: modulo DEPTH; full/empty derived from count, not pointer equality.
- Reset mid-handshake (ACK, FIFO partly full):
  - FIFO contents are discarded.
  - rfd returns to 1.
  - A producer still holding dav_=0 after reset gets its byte captured again at the next edge. This is intended; the producer is reset by the same signal.

Optional Feature:
- Macro RX_STATS_EN.
- Defined:
  - On every capture edge: rx_cnt<=rx_cnt+1, wrapping at 16'hFFFF→0.
  - On every capture edge: run_min<=min(run_min, data), unsigned compare.
  - Both cleared by reset to 0 and all ones respectively.
- Undefined:
  - No statistics registers.
  - rx_cnt tied to 0 and run_min tied to all ones.
  - Ports remain present.

Test Plan:
- Single byte: after reset, data=8'h5A, dav_=0 → next edge rfd=0, out_valid=1, out_data=8'h5A, count=1. Then dav_=1 → next edge rfd=1. Then out_ready=1 for 1 cycle → out_valid=0, count=0.
- Fill + back-pressure: DEPTH=4, out_ready=0, send 8'h10,8'h20,8'h30,8'h40 → count=4. Fifth byte 8'h50 with dav_=0 → rfd stays 1 for ≥5 cycles. Pulse out_ready 1 cycle → 8'h10 popped; next edge 8'h50 captured, rfd=0, count=4.
- Held dav_: dav_=0 for 10 cycles with data=8'h33 → exactly one push, count=1, rfd=0 throughout ACK.
- Wrap + simultaneous push/pop: out_ready=1 constantly, stream 10 bytes 0..9 → outputs 0..9 in order; count never exceeds 1. Pointers wrap twice.
- Reset mid-handshake: in ACK with count=2, assert reset 1 cycle with dav_=1 → rfd=1, count=0, out_valid=0, run_min=8'hFF, rx_cnt=0.
- RX_STATS_EN defined: send 8'h80,8'h12,8'hF0 → rx_cnt=3, run_min=8'h12. Same sequence with macro undefined → rx_cnt=0, run_min=8'hFF.
